sd_adc_decim: RTL and testbench
===============================

// Module: sd_adc_decim
// PURPOSE
//  Receive side of the audio path: the capture counterpart of the 1-bit PCM->PWM DAC.
//  Samples an external comparator, drives the 1-bit delta-sigma feedback pin and
//  decimates the bitstream with a 2nd-order CIC filter.
//  Emits unsigned 16-bit PCM in the same offset-binary format the DAC consumes
//  (0x0000 = min, 0x8000 = mid, 0xFFFF = max).
// PARAMETERS
//  DECIM_LOG2   8   log2 of the decimation ratio R; range 4..8 (R = 256 gives ~188 kHz at 48 MHz clk)
//  SYNC_STAGES  2   synchroniser flops on comp_in; range 2..3
// PORTS
//  clk        in   1   system clock; single clock domain
//  rst        in   1   asynchronous, active-high reset
//  enable     in   1   high = run; low = hold filter cleared, no output
//  comp_in    in   1   asynchronous comparator output (analog in > feedback integral)
//  fb_out     out  1   feedback bit to RC integrator = registered, synchronised comp_in
//  pcm        out  16  decimated sample, unsigned offset binary
//  pcm_valid  out  1   sample held in pcm is unread
//  pcm_ready  in   1   consumer accepts pcm this cycle when pcm_valid=1
//  overrun    out  1   sticky: a new sample arrived while pcm_valid=1
//  ovr_clr    in   1   clears overrun
// BEHAVIOUR
//  Reset values: fb_out=0, pcm=16'h0000, pcm_valid=0, overrun=0. All internal state = 0.
//  Front end:
//   - comp_in passes through SYNC_STAGES flops to give bit b.
//   - fb_out <= b every cycle, independent of enable.
//  Filter width: W = 2*DECIM_LOG2+1. Both integrators and both combs are W bits wide
//   and wrap modulo 2^W. Wrap is required and correct; no saturation inside the filter.
//  Integrators, each clk while enable=1:
//   - i1 <= i1 + b
//   - i2 <= i2 + i1
//  Phase counter:
//   - DECIM_LOG2 bits, increments each enabled clk.
//   - Terminal count (all ones) = decimation tick.
//  On each tick, comb stages:
//   - c1 = i2 - d1; d1 <= i2
//   - y  = c1 - d2; d2 <= c1
//  Output mapping:
//   - y lies in 0..R^2.
//   - pcm_next = (y >= 2^16) ? 16'hFFFF : y[15:0]
//   - Result: full-scale ones saturates to 0xFFFF.
//  Warm-up: a 2-bit counter suppresses the first 2 ticks after reset or after enable rises;
//   those comb outputs are transient. The 3rd tick onward delivers samples.
//  Latency from tick to pcm_valid=1 is one clk (registered output).
//  Handshake:
//   - A transfer occurs when pcm_valid && pcm_ready; pcm_valid falls next clk unless a
//     new sample lands the same clk.
//   - New sample with pcm_valid=0, or with a same-cycle transfer: load pcm, pcm_valid=1,
//     no overrun.
//   - New sample with pcm_valid=1 and no transfer: overwrite pcm (newest wins),
//     pcm_valid stays 1, overrun <= 1.
//   - ovr_clr concurrent with a new overrun: set wins.
//   - pcm holds its value after a read until the next sample.
//  enable=0:
//   - Clears integrators, combs, phase and warm-up counters synchronously.
//   - pcm_valid <= 0; pcm holds its value.
//   - A tick coinciding with enable falling is discarded.
//  Asynchronous rst mid-frame: all state returns to reset values immediately; the warm-up
//   rule applies again after release.
// STRUCTURE
//  Shared audio package holds:
//   - PCM_W = 16
//   - PCM_MID = 16'h8000
//   - PCM_MAX = 16'hFFFF
//   - the offset-binary format note, shared with the DAC and synth mixer
//  One sub-module, cic2_decim (params DECIM_LOG2), owns the integrators, phase counter,
//   combs and saturation. It emits sample[15:0] + tick.
//  The top level owns the synchroniser, fb_out, warm-up suppression, output register,
//   handshake and overrun flag.
// TESTING  (DECIM_LOG2=8, SYNC_STAGES=2, pcm_ready=1 unless noted)
//  1 comp_in held 1 -> fb_out=1 three clks after the input edge; every delivered pcm = 16'hFFFF.
//  2 comp_in held 0 -> every delivered pcm = 16'h0000; first pcm_valid on the 3rd tick only.
//  3 comp_in toggles each clk -> pcm = 16'h8000 (+/-1) on every sample after warm-up.
//  4 comp_in 1 for 3 of every 4 clks -> pcm = 16'hC000 (+/-1).
//  5 pcm_ready=0 over two ticks -> overrun=1, pcm = newest sample.
//    ovr_clr pulse -> overrun=0; ovr_clr on the same clk as a new overrun -> overrun stays 1.
//  6 rst asserted mid-frame, async with clk edge -> outputs at reset values in the same cycle.
//    Drop enable for 10 clks then re-raise -> no pcm_valid until 3 ticks after re-enable.

Source files
------------

// File: rtl/sd_adc_decim_pkg.sv
// Shared audio package: PCM sample format used by the DAC, the synth mixer and this ADC.
// Offset binary: 0x0000 = most negative, 0x8000 = mid-scale, 0xFFFF = most positive.
package sd_adc_decim_pkg;

   localparam int unsigned PCM_W = 16;

   typedef logic [PCM_W-1:0] pcm_t;

   localparam pcm_t PCM_MID = 16'h8000;
   localparam pcm_t PCM_MAX = 16'hFFFF;

endpackage

// File: rtl/cic2_decim.sv
// Second-order CIC decimator for a 1-bit stream: integrators, phase counter, combs and
// saturation of the R^2 full-scale result into 16-bit offset binary.
module cic2_decim
   import sd_adc_decim_pkg::*;
#(
   parameter int unsigned DECIM_LOG2 = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic bit_in,
   output pcm_t sample,
   output logic tick
);

   localparam int unsigned W  = 2 * DECIM_LOG2 + 1;
   // Wide enough to hold W bits and to expose the bit above the PCM range.
   localparam int unsigned YW = (W > PCM_W) ? W : PCM_W + 1;

   logic [W-1:0]          i1_q, i2_q, d1_q, d2_q;
   logic [W-1:0]          c1, y;
   logic [YW-1:0]         y_ext;
   logic [DECIM_LOG2-1:0] phase_q;

   assign tick  = enable & (&phase_q);
   assign c1    = i2_q - d1_q;
   assign y     = c1 - d2_q;
   assign y_ext = YW'(y);

   assign sample = (|y_ext[YW-1:PCM_W]) ? PCM_MAX : y_ext[PCM_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i1_q    <= '0;
         i2_q    <= '0;
         d1_q    <= '0;
         d2_q    <= '0;
         phase_q <= '0;
      end else if (!enable) begin
         i1_q    <= '0;
         i2_q    <= '0;
         d1_q    <= '0;
         d2_q    <= '0;
         phase_q <= '0;
      end else begin
         // Integrators wrap modulo 2^W; the comb differences stay exact regardless.
         i1_q    <= i1_q + {{(W-1){1'b0}}, bit_in};
         i2_q    <= i2_q + i1_q;
         phase_q <= phase_q + 1'b1;
         if (tick) begin
            d1_q <= i2_q;
            d2_q <= c1;
         end
      end
   end

endmodule

// File: rtl/sd_adc_decim.sv
// Delta-sigma ADC receive path: comparator synchroniser, 1-bit feedback, CIC decimation,
// warm-up suppression and a valid/ready output register with a sticky overrun flag.
module sd_adc_decim
   import sd_adc_decim_pkg::*;
#(
   parameter int unsigned DECIM_LOG2  = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic comp_in,
   output logic fb_out,
   output pcm_t pcm,
   output logic pcm_valid,
   input  logic pcm_ready,
   output logic overrun,
   input  logic ovr_clr
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   bit_s;
   logic                   fb_q;
   logic [1:0]             warm_q;
   pcm_t                   sample;
   logic                   tick;
   logic                   new_sample;
   logic                   xfer;
   pcm_t                   pcm_q, pcm_d;
   logic                   valid_q, valid_d;
   logic                   ovr_q, ovr_d;

   assign bit_s = sync_q[SYNC_STAGES-1];

   cic2_decim #(
      .DECIM_LOG2 (DECIM_LOG2)
   ) u_cic (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .bit_in (bit_s),
      .sample (sample),
      .tick   (tick)
   );

   // The first two comb outputs after a restart still contain pre-start history.
   assign new_sample = tick & (warm_q == 2'd2);
   assign xfer       = valid_q & pcm_ready;

   always_comb begin
      pcm_d   = pcm_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (!enable) begin
         valid_d = 1'b0;
      end else if (new_sample) begin
         pcm_d   = sample;
         valid_d = 1'b1;
      end else if (xfer) begin
         valid_d = 1'b0;
      end
      if (ovr_clr) begin
         ovr_d = 1'b0;
      end
      if (new_sample && valid_q && !pcm_ready) begin
         ovr_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         fb_q    <= 1'b0;
         warm_q  <= 2'd0;
         pcm_q   <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], comp_in};
         fb_q    <= bit_s;
         pcm_q   <= pcm_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         if (!enable) begin
            warm_q <= 2'd0;
         end else if (tick && (warm_q != 2'd2)) begin
            warm_q <= warm_q + 2'd1;
         end
      end
   end

   assign fb_out    = fb_q;
   assign pcm       = pcm_q;
   assign pcm_valid = valid_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_sd_adc_decim.sv
// Directed bench for sd_adc_decim: expected samples are queued as each pattern is applied
// and popped by a monitor whenever the DUT hands a sample over.
module tb_sd_adc_decim;
   import sd_adc_decim_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enable = 1'b0;
   logic comp_in;
   logic fb_out;
   pcm_t pcm;
   logic pcm_valid;
   logic pcm_ready = 1'b1;
   logic overrun;
   logic ovr_clr = 1'b0;

   int   n_chk  = 0;
   int   n_pass = 0;
   int   cyc    = 0;
   pcm_t exp_q[$];
   logic mon_en = 1'b1;

   // Comparator pattern: 0 = constant lvl, 1 = toggle each clk, 2 = high 3 of every 4 clks
   int         mode = 0;
   logic       lvl  = 1'b0;
   logic [1:0] pat_cnt = 2'd0;

   sd_adc_decim #(
      .DECIM_LOG2  (8),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .comp_in   (comp_in),
      .fb_out    (fb_out),
      .pcm       (pcm),
      .pcm_valid (pcm_valid),
      .pcm_ready (pcm_ready),
      .overrun   (overrun),
      .ovr_clr   (ovr_clr)
   );

   initial begin
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic wait_valid(input string tag, input int limit);
      cyc = 0;
      while (!pcm_valid && cyc < limit) step(1);
      check(tag, cyc, 768);
   endtask

   task automatic wait_drain(input string tag);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 4000) begin
         step(1);
         k++;
      end
      check(tag, exp_q.size(), 0);
   endtask

   initial begin
      comp_in = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         pat_cnt = pat_cnt + 2'd1;
         case (mode)
            1:       comp_in = pat_cnt[0];
            2:       comp_in = (pat_cnt != 2'd0);
            default: comp_in = lvl;
         endcase
      end
   end

   // Transfer happens at the next posedge when valid and ready are both high here.
   initial begin
      pcm_t e;
      forever begin
         @(negedge clk);
         if (mon_en && pcm_valid && pcm_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_sample", 32'(pcm), 32'hDEAD_BEEF);
            end else begin
               e = exp_q.pop_front();
               check("sample", 32'(pcm), 32'(e));
            end
         end
      end
   end

   initial begin
      step(3);
      check("rst_fb_out", 32'(fb_out), 0);
      check("rst_pcm_valid", 32'(pcm_valid), 0);
      rst = 1'b0;
      step(2);

      // Full-scale ones and feedback latency
      lvl = 1'b1;
      step(2);
      check("fb_before_3clk", 32'(fb_out), 0);
      step(1);
      check("fb_after_3clk", 32'(fb_out), 1);
      repeat (3) exp_q.push_back(PCM_MAX);
      enable = 1'b1;
      wait_drain("ones_drain");

      // All zeros, warm-up timing
      step(1);
      enable = 1'b0;
      lvl = 1'b0;
      step(4);
      repeat (3) exp_q.push_back(16'h0000);
      enable = 1'b1;
      wait_valid("zeros_first_valid_cyc", 2000);
      wait_drain("zeros_drain");

      // Toggle: mid-scale
      step(1);
      enable = 1'b0;
      mode = 1;
      step(4);
      repeat (3) exp_q.push_back(PCM_MID);
      enable = 1'b1;
      wait_drain("toggle_drain");

      // Three of four ones: 3/4 scale
      step(1);
      enable = 1'b0;
      mode = 2;
      step(4);
      repeat (3) exp_q.push_back(16'hC000);
      enable = 1'b1;
      wait_drain("q3_drain");

      // Enable drop: valid clears, pcm holds, warm-up restarts
      mon_en = 1'b0;
      pcm_ready = 1'b0;
      cyc = 0;
      while (!pcm_valid && cyc < 400) step(1);
      check("hold_pre_pcm", 32'(pcm), 32'hC000);
      enable = 1'b0;
      step(1);
      check("dis_valid", 32'(pcm_valid), 0);
      check("dis_pcm_hold", 32'(pcm), 32'hC000);
      step(9);
      exp_q.push_back(16'hC000);
      pcm_ready = 1'b1;
      mon_en = 1'b1;
      enable = 1'b1;
      wait_valid("reen_first_valid_cyc", 2000);
      wait_drain("reen_drain");

      // Overrun: zeros first, then ones while the consumer stalls
      step(1);
      enable = 1'b0;
      mon_en = 1'b0;
      pcm_ready = 1'b0;
      mode = 0;
      lvl = 1'b0;
      step(4);
      enable = 1'b1;
      wait_valid("ovr_first_valid_cyc", 2000);
      check("ovr_first_pcm", 32'(pcm), 0);
      lvl = 1'b1;
      step(1540 - cyc);
      check("ovr_set", 32'(overrun), 1);
      check("ovr_newest_pcm", 32'(pcm), 32'hFFFF);
      check("ovr_valid", 32'(pcm_valid), 1);
      ovr_clr = 1'b1;
      step(1);
      ovr_clr = 1'b0;
      check("ovr_cleared", 32'(overrun), 0);
      step(1791 - cyc);
      check("ovr_still_clear", 32'(overrun), 0);
      ovr_clr = 1'b1;
      step(1);
      ovr_clr = 1'b0;
      check("ovr_set_wins", 32'(overrun), 1);

      // Asynchronous reset between clock edges
      step(2);
      check("pre_rst_fb", 32'(fb_out), 1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_fb_out", 32'(fb_out), 0);
      check("arst_pcm", 32'(pcm), 0);
      check("arst_pcm_valid", 32'(pcm_valid), 0);
      check("arst_overrun", 32'(overrun), 0);
      step(1);
      rst = 1'b0;
      pcm_ready = 1'b1;
      mon_en = 1'b1;
      exp_q.push_back(PCM_MAX);
      wait_valid("post_rst_first_valid_cyc", 2000);
      wait_drain("post_rst_drain");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
